// File: rtl/control_pipe.sv
// control_pipe: decode control through E/M/W registers, execute redirect and in/out I/O handshake FSM
module control_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       reg_write_d,
  input  logic [2:0] result_src_d,
  input  logic       mem_write_d,
  input  logic       jump_d,
  input  logic       branch_d,
  input  logic [3:0] alu_control_d,
  input  logic       alu_src_d,
  input  logic       alu_op_and_d,
  input  logic       funct3_0_d,
  input  logic       out_issued_d,
  input  logic       in_issued_d,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic       cond_e,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       io_stall,
  output logic [3:0] alu_control_e,
  output logic       alu_src_e,
  output logic       alu_op_and_e,
  output logic       reg_write_e,
  output logic [2:0] result_src_e,
  output logic       mem_write_e,
  output logic       pc_src_e,
  output logic       reg_write_m,
  output logic [2:0] result_src_m,
  output logic       mem_write_m,
  output logic       reg_write_w,
  output logic [2:0] result_src_w
);
  logic [15:0] d_w, e_q;
  logic [4:0]  m_q;
  logic [3:0]  w_q;
  logic        done_q, hold_w, hs_w;
  assign d_w = {in_issued_d, out_issued_d, funct3_0_d, alu_op_and_d, alu_src_d, alu_control_d,
                branch_d, jump_d, mem_write_d, result_src_d, reg_write_d};
  assign in_ready  = ~rst & ~done_q & e_q[15] & in_valid;
  assign out_valid = ~rst & ~done_q & e_q[14];
  assign io_stall  = ~done_q & ((e_q[15] & ~in_valid) | (e_q[14] & ~out_ready));
  assign hold_w    = stall_e | io_stall;
  assign hs_w      = in_ready | (out_valid & out_ready);
  assign pc_src_e  = e_q[5] | (e_q[6] & (cond_e ^ e_q[13]));
  assign reg_write_e   = e_q[0];
  assign result_src_e  = e_q[3:1];
  assign mem_write_e   = e_q[4];
  assign alu_control_e = e_q[10:7];
  assign alu_src_e     = e_q[11];
  assign alu_op_and_e  = e_q[12];
  assign reg_write_m   = m_q[0];
  assign result_src_m  = m_q[3:1];
  assign mem_write_m   = m_q[4];
  assign reg_write_w   = w_q[0];
  assign result_src_w  = w_q[3:1];
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      done_q <= 1'b0;
    end else begin
      e_q    <= hold_w ? e_q : flush_e ? '0 : d_w;
      m_q    <= hold_w ? '0 : e_q[4:0];
      w_q    <= m_q[3:0];
      done_q <= done_q ? hold_w : (hs_w & stall_e);
    end
  end
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed scoreboard bench for control_pipe
module tb_control_pipe;
  logic clk = 1'b0;
  logic rst, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, alu_op_and_d, funct3_0_d;
  logic out_issued_d, in_issued_d, stall_e, flush_e, cond_e, in_valid, out_ready;
  logic [2:0] result_src_d;
  logic [3:0] alu_control_d;
  logic in_ready, out_valid, io_stall, alu_src_e, alu_op_and_e, reg_write_e, mem_write_e, pc_src_e;
  logic reg_write_m, mem_write_m, reg_write_w;
  logic [3:0] alu_control_e;
  logic [2:0] result_src_e, result_src_m, result_src_w;
  typedef struct {int cyc; string name; int sel; logic [3:0] exp;} chk_t;
  chk_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  control_pipe dut (
    .clk(clk), .rst(rst), .reg_write_d(reg_write_d), .result_src_d(result_src_d),
    .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d), .alu_control_d(alu_control_d),
    .alu_src_d(alu_src_d), .alu_op_and_d(alu_op_and_d), .funct3_0_d(funct3_0_d),
    .out_issued_d(out_issued_d), .in_issued_d(in_issued_d), .stall_e(stall_e), .flush_e(flush_e),
    .cond_e(cond_e), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .io_stall(io_stall), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .alu_op_and_e(alu_op_and_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .pc_src_e(pc_src_e), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w)
  );
  function automatic logic [3:0] get(int s);
    return s == 0  ? {3'b0, pc_src_e} :
           s == 1  ? {3'b0, io_stall} :
           s == 2  ? {3'b0, in_ready} :
           s == 3  ? {3'b0, out_valid} :
           s == 4  ? {3'b0, reg_write_e} :
           s == 5  ? {1'b0, result_src_e} :
           s == 6  ? {3'b0, mem_write_e} :
           s == 7  ? alu_control_e :
           s == 8  ? {3'b0, reg_write_m} :
           s == 9  ? {1'b0, result_src_m} :
           s == 10 ? {3'b0, reg_write_w} :
           s == 11 ? {1'b0, result_src_w} :
           s == 12 ? {3'b0, alu_src_e} :
           s == 13 ? {3'b0, alu_op_and_e} : {3'b0, mem_write_m};
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t e;
      logic [3:0] a;
      e = q.pop_front();
      a = get(e.sel);
      n_chk++;
      if (e.cyc != cyc || a !== e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", e.name, e.cyc, a, e.exp);
      end
    end
  end
  task automatic ex(string n, int s, logic [3:0] v);
    q.push_back('{cyc, n, s, v});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_d();
    {reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, alu_op_and_d, funct3_0_d} = '0;
    {out_issued_d, in_issued_d, result_src_d, alu_control_d} = '0;
  endtask
  initial begin
    clr_d();
    {stall_e, flush_e, cond_e, in_valid, out_ready} = '0;
    rst = 1'b1;
    reg_write_d = 1'b1; jump_d = 1'b1; alu_control_d = 4'hf; stall_e = 1'b1;
    tick();
    tick();
    ex("rst_pc_src", 0, 0); ex("rst_io_stall", 1, 0); ex("rst_reg_write_e", 4, 0);
    ex("rst_alu_e", 7, 0); ex("rst_reg_write_m", 8, 0); ex("rst_reg_write_w", 10, 0);
    ex("rst_in_ready", 2, 0); ex("rst_out_valid", 3, 0);
    tick();
    rst = 1'b0; clr_d(); stall_e = 1'b0;
    tick();
    reg_write_d = 1'b1; result_src_d = 3'b010;
    tick(); clr_d();
    ex("pipe_reg_write_e", 4, 1); ex("pipe_result_e", 5, 2); ex("pipe_reg_write_m0", 8, 0);
    tick();
    ex("pipe_reg_write_m", 8, 1); ex("pipe_result_m", 9, 2); ex("pipe_reg_write_e0", 4, 0);
    tick();
    ex("pipe_reg_write_w", 10, 1); ex("pipe_result_w", 11, 2); ex("pipe_reg_write_m1", 8, 0);
    tick();
    ex("pipe_reg_write_w0", 10, 0); ex("pipe_result_w0", 11, 0);
    reg_write_d = 1'b1; alu_src_d = 1'b1; flush_e = 1'b1;
    tick(); clr_d(); flush_e = 1'b0;
    ex("flush_reg_write_e", 4, 0); ex("flush_alu_src_e", 12, 0);
    reg_write_d = 1'b1; alu_control_d = 4'h5; alu_op_and_d = 1'b1;
    tick(); clr_d();
    ex("load_alu_e", 7, 5); ex("load_alu_and_e", 13, 1);
    stall_e = 1'b1; mem_write_d = 1'b1;
    tick();
    ex("stall_reg_write_e", 4, 1); ex("stall_alu_e", 7, 5); ex("stall_mem_write_e", 6, 0);
    ex("stall_bubble_m", 8, 0);
    flush_e = 1'b1;
    tick();
    ex("stallflush_reg_write_e", 4, 1); ex("stallflush_alu_e", 7, 5); ex("stallflush_bubble_m", 8, 0);
    stall_e = 1'b0; flush_e = 1'b0; clr_d();
    tick();
    ex("release_reg_write_e", 4, 0); ex("release_reg_write_m", 8, 1);
    branch_d = 1'b1;
    tick(); clr_d();
    cond_e = 1'b1; branch_d = 1'b1; funct3_0_d = 1'b1;
    ex("beq_taken", 0, 1);
    tick(); clr_d();
    cond_e = 1'b1; jump_d = 1'b1;
    ex("bne_not_taken", 0, 0);
    tick(); clr_d();
    cond_e = 1'b0;
    ex("jump_taken", 0, 1);
    tick();
    cond_e = 1'b1;
    ex("no_branch", 0, 0);
    tick();
    cond_e = 1'b0;
    in_issued_d = 1'b1; reg_write_d = 1'b1; result_src_d = 3'b011;
    tick(); clr_d();
    mem_write_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex("inwait_io_stall", 1, 1); ex("inwait_in_ready", 2, 0);
      ex("inwait_hold_e", 5, 3); ex("inwait_bubble_m", 8, 0);
      tick();
    end
    in_valid = 1'b1;
    ex("in_ready_on", 2, 1); ex("in_io_stall_off", 1, 0); ex("in_bubble_m", 8, 0);
    tick();
    ex("in_ready_once", 2, 0); ex("in_advance_e", 6, 1); ex("in_advance_m", 8, 1);
    ex("in_advance_result_m", 9, 3);
    clr_d(); in_valid = 1'b0;
    out_issued_d = 1'b1; reg_write_d = 1'b1;
    tick(); clr_d();
    out_ready = 1'b1; stall_e = 1'b1;
    ex("out_valid_first", 3, 1); ex("out_io_stall", 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ex("out_done_valid", 3, 0); ex("out_done_io_stall", 1, 0); ex("out_done_hold_e", 4, 1);
      tick();
    end
    stall_e = 1'b0;
    ex("out_release_valid", 3, 0); ex("out_release_hold_e", 4, 1); ex("out_release_m", 8, 0);
    tick();
    ex("out_adv_e", 4, 0); ex("out_adv_m", 8, 1); ex("out_adv_valid", 3, 0);
    out_issued_d = 1'b1;
    tick(); clr_d();
    ex("out_idle_valid", 3, 1); ex("out_idle_io_stall", 1, 0);
    out_issued_d = 1'b1;
    tick(); clr_d();
    out_ready = 1'b0;
    ex("out_wait_io_stall", 1, 1); ex("out_wait_valid", 3, 1);
    tick();
    out_ready = 1'b1;
    ex("out_accept_io_stall", 1, 0);
    tick();
    out_ready = 1'b0;
    in_issued_d = 1'b1; reg_write_d = 1'b1;
    tick(); clr_d();
    ex("rstwait_io_stall", 1, 1);
    tick();
    rst = 1'b1; in_valid = 1'b1;
    ex("rstcycle_in_ready", 2, 0);
    tick();
    rst = 1'b0;
    ex("postrst_io_stall", 1, 0); ex("postrst_in_ready", 2, 0); ex("postrst_reg_write_e", 4, 0);
    ex("postrst_pc_src", 0, 0); ex("postrst_out_valid", 3, 0);
    tick();
    ex("postrst_in_ready2", 2, 0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/control_pipe.md
# control_pipe

Carries decoded control fields from the decode stage through the execute, memory and writeback pipeline registers. It is the consuming end of the decode-stage control bundle, which is produced by the main decoder. It evaluates branch/jump redirection in execute. It also runs the I/O handshake for `in`/`out` instructions, asserting `io_stall` until the external device side completes. It sits between the decoder and the datapath stage registers, beside the hazard unit.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `reg_write_d`  in  1  decode-stage control
- `result_src_d`  in  3  decode-stage control
- `mem_write_d`  in  1  decode-stage control
- `jump_d`  in  1  decode-stage control
- `branch_d`  in  1  decode-stage control
- `alu_control_d`  in  4  decode-stage control
- `alu_src_d`  in  1  decode-stage control
- `alu_op_and_d`  in  1  decode-stage control
- `funct3_0_d`  in  1  decode-stage control
- `out_issued_d`  in  1  decode-stage control
- `in_issued_d`  in  1  decode-stage control
- `stall_e`  in  1  hazard unit: hold the E register
- `flush_e`  in  1  hazard unit: load a bubble into E
- `cond_e`  in  1  ALU compare result (zero/less-than) for the instruction in E
- `in_valid`  in  1  input device has a word
- `in_ready`  out  1  input word consumed this cycle
- `out_valid`  out  1  output word presented this cycle
- `out_ready`  in  1  output device accepts
- `io_stall`  out  1  E is waiting on an I/O handshake; hazard unit must stall F/D
- `alu_control_e`  out  4  E-stage control
- `alu_src_e`  out  1  E-stage control
- `alu_op_and_e`  out  1  E-stage control
- `reg_write_e`  out  1  E-stage control
- `result_src_e`  out  3  E-stage control
- `mem_write_e`  out  1  E-stage control
- `pc_src_e`  out  1  redirect fetch
- `reg_write_m`  out  1  M-stage control
- `result_src_m`  out  3  M-stage control
- `mem_write_m`  out  1  M-stage control
- `reg_write_w`  out  1  W-stage control
- `result_src_w`  out  3  W-stage control

## Operation
- E register holds all 11 decode fields. M and W hold the fields listed.
- Bubble means all fields are 0.
- `hold_e = stall_e | io_stall`.
  - If `hold_e` is 1: E keeps its value, M loads a bubble, and W loads M. `flush_e` is ignored in a hold cycle.
  - Otherwise, if `flush_e` is 1: E loads a bubble.
  - Otherwise: E loads the D fields.
  - When not holding, M loads E and W loads M.
- `pc_src_e = jump_e | (branch_e & (cond_e ^ funct3_0_e))`. This is combinational and is not masked by stall. The hazard unit owns any flush it triggers.
- I/O FSM has two states, IDLE and DONE.
  - In IDLE:
    - `in_ready = in_issued_e & in_valid`.
    - `out_valid = out_issued_e`.
    - `io_stall = (in_issued_e & ~in_valid) | (out_issued_e & ~out_ready)`.
    - If a handshake completes (`in_ready`, or `out_valid & out_ready`) while `stall_e` is 1, go to DONE.
  - In DONE: `in_ready = 0`, `out_valid = 0`, `io_stall = 0`. Return to IDLE on the first cycle E advances (`hold_e = 0`).
  - This guarantees exactly one handshake per I/O instruction, even under an external hold.
- `in_issued_e` and `out_issued_e` are never both 1. If they are, behaviour is unspecified.

## Timing
- Reset:
  - All E/M/W fields are 0.
  - FSM is IDLE.
  - Every output is therefore 0: `pc_src_e`, `io_stall`, `in_ready` and `out_valid` are all 0.
  - Reset overrides stall and flush in the same cycle.
- Latency: D→E, E→M and M→W are each 1 cycle. A D-stage field reaches W 3 cycles after capture, with no stalls.
- `io_stall`, `in_ready`, `out_valid` and `pc_src_e` are combinational from E state and inputs. There is no registered delay.
- Handshake:
  - Input word is consumed in the cycle `in_ready` is 1.
  - Output word is transferred in the cycle `out_valid & out_ready`.
  - The device may hold `in_valid`/`out_ready` low indefinitely. The pipeline waits, with a bubble entering M each cycle.
- Reset asserted mid-wait: FSM goes to IDLE, E becomes a bubble, and no handshake occurs in the reset cycle.

## Test plan
- **Straight pipeline:** D with reg_write=1, result_src=3'b010 for one cycle, no stalls → reg_write_e/result_src_e at +1, _m at +2, _w at +3. All then return to 0.
- **Flush and stall:**
  - flush_e=1 with D reg_write=1 → E is all zero next cycle.
  - stall_e=1 with E reg_write=1 → E holds, M=0.
  - stall_e and flush_e together → E holds.
- **Branch:**
  - branch_e=1, funct3_0_e=0, cond_e=1 → pc_src_e=1.
  - funct3_0_e=1, cond_e=1 → pc_src_e=0.
  - jump_e=1 → pc_src_e=1 regardless of cond.
- **Input wait:** in_issued_e=1, in_valid=0 for 3 cycles → io_stall=1 for 3 cycles, E held, three bubbles into M. Then in_valid=1 → in_ready=1 for exactly 1 cycle, io_stall=0, E advances.
- **Output under external hold:** out_issued_e=1, out_ready=1, stall_e=1 for 4 cycles → out_valid=1 only in the first cycle, FSM DONE, io_stall=0. stall_e drops → E advances, FSM IDLE.
- **Reset mid-wait:** in_issued_e=1, io_stall=1, rst=1 → next cycle all outputs 0 and FSM IDLE. in_valid=1 afterwards → in_ready stays 0.
